// File: rtl/gnr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gnr_pkg : shared constants and helpers for gene-regulatory-network nodes
// Revision: 1.0
// ---------------------------------------------------------------------------
package gnr_pkg;

  localparam int K_MAX = 6;

  // Common 3-input truth tables; bit i is the output for regulator vector i.
  localparam logic [7:0] LUT_AND3 = 8'h80;
  localparam logic [7:0] LUT_OR3  = 8'hFE;
  localparam logic [7:0] LUT_MAJ3 = 8'hE8;
  localparam logic [7:0] LUT_XOR3 = 8'h96;

  function automatic int div_cnt_w(input int slow_div);
    return (slow_div <= 2) ? 1 : $clog2(slow_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gnr_lut_rf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gnr_lut_rf : 2^K x 1 truth-table register file, one write / two read ports
// Revision: 1.0
// ---------------------------------------------------------------------------
module gnr_lut_rf #(
  parameter int            K    = 3,
  parameter logic [2**K-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [K-1:0] waddr,
  input  logic         wdata,
  input  logic [K-1:0] raddr0,
  input  logic [K-1:0] raddr1,
  output logic         rdata0,
  output logic         rdata1
);

  logic [2**K-1:0] lut_q;
  logic [2**K-1:0] lut_d;

  always_comb begin
    lut_d = lut_q;
    if (we) lut_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lut_q <= INIT;
    else        lut_q <= lut_d;
  end

  // Reads see the registered table, so a same-cycle write is not yet visible.
  assign rdata0 = lut_q[raddr0];
  assign rdata1 = lut_q[raddr1];

endmodule
`default_nettype wire

// File: rtl/gnr_node_lut.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gnr_node_lut : GRN node with slow/fast trajectories over a loadable LUT
// Revision: 1.0
// ---------------------------------------------------------------------------
module gnr_node_lut #(
  parameter int              K        = 3,
  parameter int              SLOW_DIV = 2,
  parameter logic [2**K-1:0] LUT_INIT = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [K-1:0]     cfg_addr,
  input  logic             cfg_data,
  input  logic             reset_nos,
  input  logic             init_state,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic [K-1:0]     reg_s0,
  input  logic [K-1:0]     reg_s1,
  output logic             s0,
  output logic             s1,
  output logic             il_s0,
  output logic             il_s1,
  output logic [CNT_W-1:0] steps,
  output logic             steps_sat
);
  import gnr_pkg::*;

  localparam int               DIV_W    = div_cnt_w(SLOW_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  if (K < 1 || K > K_MAX) begin : g_k_check
    $error("gnr_node_lut: K out of range");
  end

  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             lut_s0, lut_s1;
  logic [K-1:0]     raddr0, raddr1;

  // Regulator vectors only reach the LUT while their strobe is high.
  assign raddr0 = start_s0 ? reg_s0 : '0;
  assign raddr1 = start_s1 ? reg_s1 : '0;

  gnr_lut_rf #(
    .K    (K),
    .INIT (LUT_INIT)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .rdata0 (lut_s0),
    .rdata1 (lut_s1)
  );

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    div_cnt_d = div_cnt_q;
    steps_d   = steps_q;
    if (reset_nos) begin
      s0_d      = init_state;
      s1_d      = init_state;
      div_cnt_d = '0;
      steps_d   = '0;
    end else begin
      if (start_s0) begin
        if (div_cnt_q == '0) s0_d = lut_s0;
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      end
      if (start_s1) begin
        s1_d = lut_s1;
        if (!(&steps_q)) steps_d = steps_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      div_cnt_q <= '0;
      steps_q   <= '0;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      div_cnt_q <= div_cnt_d;
      steps_q   <= steps_d;
    end
  end

  assign s0        = s0_q;
  assign s1        = s1_q;
  assign il_s0     = s0_q;
  assign il_s1     = s1_q;
  assign steps     = steps_q;
  assign steps_sat = &steps_q;

endmodule
`default_nettype wire

// File: tb/tb_gnr_node_lut.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gnr_node_lut : scoreboard bench for gnr_node_lut (three parameter sets)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gnr_node_lut;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic       cfg_data = 1'b0;
  logic       reset_nos = 1'b0;
  logic       init_state = 1'b0;
  logic       start_s0 = 1'b0;
  logic       start_s1 = 1'b0;
  logic [2:0] reg_s0 = '0;
  logic [2:0] reg_s1 = '0;

  logic        a_s0, a_s1, a_il0, a_il1, a_sat;
  logic [15:0] a_steps;
  logic        b_s0, b_s1, b_il0, b_il1, b_sat;
  logic [15:0] b_steps;
  logic        c_s0, c_s1, c_il0, c_il1, c_sat;
  logic [2:0]  c_steps;

  always #5 clk = ~clk;

  gnr_node_lut #(.K(3), .SLOW_DIV(2), .LUT_INIT(8'hE8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .reg_s0(reg_s0), .reg_s1(reg_s1), .s0(a_s0), .s1(a_s1), .il_s0(a_il0), .il_s1(a_il1),
    .steps(a_steps), .steps_sat(a_sat));

  gnr_node_lut #(.K(3), .SLOW_DIV(3), .LUT_INIT(8'hE8), .CNT_W(16)) dut_div3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .reg_s0(reg_s0), .reg_s1(reg_s1), .s0(b_s0), .s1(b_s1), .il_s0(b_il0), .il_s1(b_il1),
    .steps(b_steps), .steps_sat(b_sat));

  gnr_node_lut #(.K(3), .SLOW_DIV(2), .LUT_INIT(8'hE8), .CNT_W(3)) dut_cnt3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .reg_s0(reg_s0), .reg_s1(reg_s1), .s0(c_s0), .s1(c_s1), .il_s0(c_il0), .il_s1(c_il1),
    .steps(c_steps), .steps_sat(c_sat));

  typedef struct {
    int          id;
    logic        s0;
    logic        s1;
    logic [15:0] steps;
    logic        sat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: each negedge, compare every response expected from the last edge.
  always @(negedge clk) begin
    exp_t        e;
    logic        g_s0, g_s1, g_il0, g_il1, g_sat;
    logic [15:0] g_steps;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin g_s0 = a_s0; g_s1 = a_s1; g_il0 = a_il0; g_il1 = a_il1; g_steps = a_steps; g_sat = a_sat; end
        1:       begin g_s0 = b_s0; g_s1 = b_s1; g_il0 = b_il0; g_il1 = b_il1; g_steps = b_steps; g_sat = b_sat; end
        default: begin g_s0 = c_s0; g_s1 = c_s1; g_il0 = c_il0; g_il1 = c_il1; g_steps = {13'd0, c_steps}; g_sat = c_sat; end
      endcase
      checks++;
      if (g_s0 !== e.s0 || g_s1 !== e.s1 || g_il0 !== e.s0 || g_il1 !== e.s1 ||
          g_steps !== e.steps || g_sat !== e.sat) begin
        errors++;
        $display("FAIL %s (inst %0d): got s0=%b s1=%b il_s0=%b il_s1=%b steps=%0d sat=%b, expected s0=%b s1=%b steps=%0d sat=%b",
                 e.name, e.id, g_s0, g_s1, g_il0, g_il1, g_steps, g_sat, e.s0, e.s1, e.steps, e.sat);
      end
    end
  end

  task automatic push(input int id, input logic s0, input logic s1, input int st, input string name);
    exp_t e;
    e.id    = id;
    e.s0    = s0;
    e.s1    = s1;
    e.steps = 16'(st);
    e.sat   = (id == 2) ? (st == 7) : 1'b0;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rn, input logic nos, input logic init,
                       input logic st0, input logic [2:0] r0,
                       input logic st1, input logic [2:0] r1,
                       input logic we, input logic [2:0] wa, input logic wd);
    @(negedge clk);
    #1;
    rst_n      = rn;
    reset_nos  = nos;
    init_state = init;
    start_s0   = st0;
    reg_s0     = r0;
    start_s1   = st1;
    reg_s1     = r1;
    cfg_we     = we;
    cfg_addr   = wa;
    cfg_data   = wd;
  endtask

  task automatic idle();                   drive(1, 0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0); endtask
  task automatic nos(input logic init);    drive(1, 1, init, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0); endtask
  task automatic step0(input logic [2:0] r); drive(1, 0, 0, 1, r, 0, 3'd0, 0, 3'd0, 0); endtask
  task automatic step1(input logic [2:0] r); drive(1, 0, 0, 0, 3'd0, 1, r, 0, 3'd0, 0); endtask

  initial begin
    // Power-on reset state (MAJ3 table: only vectors 3,5,6,7 map to 1)
    @(negedge clk);
    #1;
    push(0, 0, 0, 0, "por_dut");
    push(2, 0, 0, 0, "por_cnt3");

    nos(1);           push(0, 1, 1, 0, "nos_init1");

    // SLOW_DIV=2: pulses 1 and 3 update, 2 and 4 hold
    step0(3'b001);    push(0, 0, 1, 0, "div2_p1");
    step0(3'b011);    push(0, 0, 1, 0, "div2_p2_hold");
    step0(3'b011);    push(0, 1, 1, 0, "div2_p3");
    step0(3'b001);    push(0, 1, 1, 0, "div2_p4_hold");

    // SLOW_DIV=3: pulses 1 and 4 update
    nos(1);           push(1, 1, 1, 0, "div3_nos");
    step0(3'b001);    push(1, 0, 1, 0, "div3_p1");
    step0(3'b011);    push(1, 0, 1, 0, "div3_p2_hold");
    step0(3'b011);    push(1, 0, 1, 0, "div3_p3_hold");
    step0(3'b011);    push(1, 1, 1, 0, "div3_p4");

    // Fast path and saturating counter
    nos(0);           push(0, 0, 0, 0, "fast_nos"); push(2, 0, 0, 0, "cnt3_nos");
    for (int i = 1; i <= 9; i++) begin
      step1(3'b110);
      push(0, 0, 1, i, "fast_step");
      push(2, 0, 1, (i > 7) ? 7 : i, "cnt3_step");
    end

    // LUT write in the same cycle as a fast update uses the old bit
    drive(1, 0, 0, 0, 3'd0, 1, 3'b110, 1, 3'b110, 0);
    push(0, 0, 1, 10, "lut_wr_same_cycle");
    step1(3'b110);    push(0, 0, 0, 11, "lut_wr_next");

    // reset_nos wins over both strobes and clears the divider
    nos(1);           push(0, 1, 1, 0, "prio_setup");
    drive(1, 0, 0, 1, 3'b111, 1, 3'b111, 0, 3'd0, 0);
    push(0, 1, 1, 1, "prio_both");
    drive(1, 1, 0, 1, 3'b111, 1, 3'b111, 0, 3'd0, 0);
    push(0, 0, 0, 0, "prio_nos");
    step0(3'b111);    push(0, 1, 0, 0, "prio_div_cleared");

    // Async reset between two slow pulses
    nos(0);           push(0, 0, 0, 0, "rst_setup");
    step0(3'b111);    push(0, 1, 0, 0, "rst_pre");
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(0, 0, 0, 0, "async_rst_dut");
    push(1, 0, 0, 0, "async_rst_div3");
    push(2, 0, 0, 0, "async_rst_cnt3");
    idle();           push(0, 0, 0, 0, "rst_release");
    step0(3'b111);    push(0, 1, 0, 0, "post_rst_s0");
    step1(3'b110);    push(0, 1, 1, 1, "lut_restored");
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked, required 0", sb.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
